// File: rtl/reg_transfer_sequencer.sv
// Register transfer sequencer: drives a single-ported register file through
// MOV, SWAP, load-immediate and clear operations over a shared data bus.
module reg_transfer_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [1:0]            reqOp,
    input  logic [2:0]            reqSrc,
    input  logic [2:0]            reqDst,
    input  logic [DATA_WIDTH-1:0] reqImm,
    input  logic [DATA_WIDTH-1:0] busIn,
    output logic [2:0]            rOutSel,
    output logic                  rOutEn,
    output logic [2:0]            rInSel,
    output logic                  rInEn,
    output logic [DATA_WIDTH-1:0] busOut,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] WR_A = 3'd3;
    localparam logic [2:0] WR_B = 3'd4;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [1:0]            op_q;
    logic [2:0]            src_q;
    logic [2:0]            dst_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] tmp_a;
    logic [DATA_WIDTH-1:0] tmp_b;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    if (reqOp == OP_MOV || reqOp == OP_SWAP) next_state = RD_A;
                    else                                      next_state = WR_A;
                end
            end
            RD_A:    next_state = (op_q == OP_SWAP) ? RD_B : WR_A;
            RD_B:    next_state = WR_A;
            WR_A:    next_state = (op_q == OP_SWAP) ? WR_B : IDLE;
            WR_B:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands are latched only on acceptance, so request inputs are ignored while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= OP_MOV;
            src_q <= '0;
            dst_q <= '0;
            imm_q <= '0;
            tmp_a <= '0;
            tmp_b <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && reqValid) begin
                op_q  <= reqOp;
                src_q <= reqSrc;
                dst_q <= reqDst;
                imm_q <= reqImm;
            end
            if (state == RD_A) tmp_a <= busIn;
            if (state == RD_B) tmp_b <= busIn;
        end
    end

    // All bus controls decode from registered state; ready is also gated off while in reset.
    assign reqReady = (state == IDLE) && rst;
    assign busy     = (state != IDLE);
    assign rOutEn   = (state == RD_A) || (state == RD_B);
    assign rInEn    = (state == WR_A) || (state == WR_B);
    assign rOutSel  = (state == RD_B) ? dst_q : src_q;
    assign rInSel   = (state == WR_B) ? src_q : dst_q;
    assign done     = (state == WR_B) || ((state == WR_A) && (op_q != OP_SWAP));

    always_comb begin
        busOut = '0;
        case (state)
            WR_A: begin
                case (op_q)
                    OP_MOV, OP_SWAP: busOut = tmp_a;
                    OP_LDI:          busOut = imm_q;
                    default:         busOut = '0;
                endcase
            end
            WR_B:    busOut = tmp_b;
            default: busOut = '0;
        endcase
    end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed self-checking bench for reg_transfer_sequencer with a small
// register-file model answering reads and absorbing writes.
module tb_reg_transfer_sequencer;

    logic       clk;
    logic       rst;
    logic       reqValid;
    logic       reqReady;
    logic [1:0] reqOp;
    logic [2:0] reqSrc;
    logic [2:0] reqDst;
    logic [7:0] reqImm;
    logic [7:0] busIn;
    logic [2:0] rOutSel;
    logic       rOutEn;
    logic [2:0] rInSel;
    logic       rInEn;
    logic [7:0] busOut;
    logic       busy;
    logic       done;

    logic [7:0] regs [8];
    int checks;
    int failures;

    reg_transfer_sequencer #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
        .reqOp(reqOp), .reqSrc(reqSrc), .reqDst(reqDst), .reqImm(reqImm),
        .busIn(busIn), .rOutSel(rOutSel), .rOutEn(rOutEn), .rInSel(rInSel),
        .rInEn(rInEn), .busOut(busOut), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign busIn = rOutEn ? regs[rOutSel] : 8'h00;

    always @(posedge clk) begin
        if (rst && rInEn) regs[rInSel] <= busOut;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] s,
                         input logic [2:0] d, input logic [7:0] imm);
        reqValid = v;
        reqOp    = op;
        reqSrc   = s;
        reqDst   = d;
        reqImm   = imm;
    endtask

    // Bus protocol invariants sampled on every falling edge.
    always @(negedge clk) begin
        check("inv_no_overlap", {31'd0, rInEn & rOutEn}, 32'd0);
        check("inv_busout_idle", (rInEn == 1'b0) ? {24'd0, busOut} : 32'd0, 32'd0);
        check("inv_ready_busy", {31'd0, reqReady & busy}, 32'd0);
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
        regs[0] <= 8'h00; regs[1] <= 8'h11; regs[2] <= 8'h99; regs[3] <= 8'hA7;
        regs[4] <= 8'h3C; regs[5] <= 8'h00; regs[6] <= 8'h66; regs[7] <= 8'h00;

        // Reset state
        #12;
        check("rst_rOutEn", rOutEn, 0);
        check("rst_rInEn", rInEn, 0);
        check("rst_rOutSel", rOutSel, 0);
        check("rst_rInSel", rInSel, 0);
        check("rst_busOut", busOut, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_reqReady", reqReady, 0);
        @(negedge clk) rst = 1'b1;
        step();
        check("post_rst_ready", reqReady, 1);

        // MOV r3 -> r5, with reqValid held in IDLE before any edge
        drive(1'b1, 2'b00, 3'd3, 3'd5, 8'h00);
        check("idle_valid_no_rd", rOutEn, 0);
        check("idle_valid_no_wr", rInEn, 0);
        step();
        drive(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
        check("mov_c1_rOutEn", rOutEn, 1);
        check("mov_c1_rOutSel", rOutSel, 3);
        check("mov_c1_busy", busy, 1);
        check("mov_c1_ready", reqReady, 0);
        check("mov_c1_done", done, 0);
        step();
        check("mov_c2_rInEn", rInEn, 1);
        check("mov_c2_rInSel", rInSel, 5);
        check("mov_c2_busOut", busOut, 8'hA7);
        check("mov_c2_done", done, 1);
        check("mov_c2_rOutEn", rOutEn, 0);
        step();
        check("mov_c3_ready", reqReady, 1);
        check("mov_c3_busy", busy, 0);
        check("mov_c3_done", done, 0);
        check("mov_r5", regs[5], 8'hA7);

        // SWAP r1 <-> r6
        drive(1'b1, 2'b01, 3'd1, 3'd6, 8'h00);
        step();
        drive(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
        check("swap_c1_rOutSel", rOutSel, 1);
        check("swap_c1_rOutEn", rOutEn, 1);
        check("swap_c1_done", done, 0);
        step();
        check("swap_c2_rOutSel", rOutSel, 6);
        check("swap_c2_rOutEn", rOutEn, 1);
        check("swap_c2_done", done, 0);
        check("swap_c2_busy", busy, 1);
        step();
        check("swap_c3_rInEn", rInEn, 1);
        check("swap_c3_rInSel", rInSel, 6);
        check("swap_c3_busOut", busOut, 8'h11);
        check("swap_c3_done", done, 0);
        step();
        check("swap_c4_rInSel", rInSel, 1);
        check("swap_c4_busOut", busOut, 8'h66);
        check("swap_c4_done", done, 1);
        check("swap_c4_busy", busy, 1);
        step();
        check("swap_c5_ready", reqReady, 1);
        check("swap_c5_busy", busy, 0);
        check("swap_r6", regs[6], 8'h11);
        check("swap_r1", regs[1], 8'h66);

        // LDI r7 then CLR r2 back-to-back, reqValid held; mid-op input change ignored
        drive(1'b1, 2'b10, 3'd0, 3'd7, 8'h5C);
        step();
        drive(1'b1, 2'b11, 3'd0, 3'd2, 8'hFF);
        check("ldi_rInEn", rInEn, 1);
        check("ldi_rInSel", rInSel, 7);
        check("ldi_busOut", busOut, 8'h5C);
        check("ldi_done", done, 1);
        step();
        check("ldi_gap_ready", reqReady, 1);
        check("ldi_gap_rInEn", rInEn, 0);
        step();
        drive(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
        check("clr_rInSel", rInSel, 2);
        check("clr_busOut", busOut, 8'h00);
        check("clr_done", done, 1);
        step();
        check("clr_idle_ready", reqReady, 1);
        check("ldi_r7", regs[7], 8'h5C);
        check("clr_r2", regs[2], 8'h00);

        // Reset during RD_B of SWAP r1 <-> r6 (r1=66, r6=11)
        drive(1'b1, 2'b01, 3'd1, 3'd6, 8'h00);
        step();
        drive(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
        step();
        check("abort_in_rdb", rOutSel, 6);
        #2 rst = 1'b0;
        #1;
        check("abort_rOutEn", rOutEn, 0);
        check("abort_rInEn", rInEn, 0);
        check("abort_busy", busy, 0);
        check("abort_busOut", busOut, 0);
        check("abort_rOutSel", rOutSel, 0);
        check("abort_ready", reqReady, 0);
        step();
        step();
        check("abort_no_wr", rInEn, 0);
        check("abort_r1", regs[1], 8'h66);
        check("abort_r6", regs[6], 8'h11);
        @(negedge clk) rst = 1'b1;
        step();

        // MOV r6 -> r0 after recovery
        drive(1'b1, 2'b00, 3'd6, 3'd0, 8'h00);
        step();
        drive(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
        check("rec_c1_rOutSel", rOutSel, 6);
        step();
        check("rec_c2_busOut", busOut, 8'h11);
        check("rec_c2_done", done, 1);
        step();
        check("rec_r0", regs[0], 8'h11);

        // src == dst for MOV and SWAP on r4 (0x3C)
        drive(1'b1, 2'b00, 3'd4, 3'd4, 8'h00);
        step();
        drive(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
        check("movself_c1_rOutSel", rOutSel, 4);
        step();
        check("movself_c2_rInSel", rInSel, 4);
        check("movself_c2_busOut", busOut, 8'h3C);
        check("movself_c2_done", done, 1);
        step();
        drive(1'b1, 2'b01, 3'd4, 3'd4, 8'h00);
        step();
        drive(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
        check("swapself_c1_rd", rOutEn, 1);
        step();
        check("swapself_c2_rd", rOutEn, 1);
        step();
        check("swapself_c3_busOut", busOut, 8'h3C);
        check("swapself_c3_done", done, 0);
        step();
        check("swapself_c4_busOut", busOut, 8'h3C);
        check("swapself_c4_done", done, 1);
        step();
        check("swapself_r4", regs[4], 8'h3C);
        check("swapself_ready", reqReady, 1);

        // Random op stream; invariants checked on every falling edge
        for (int i = 0; i < 30; i++) begin
            int budget;
            budget = 0;
            while (!reqReady && budget < 10) begin
                step();
                budget++;
            end
            check("rand_ready_timeout", reqReady, 1);
            drive(1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            step();
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            check("rand_accepted_busy", busy, 1);
            drive(1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
        end
        begin
            int budget;
            budget = 0;
            while (busy && budget < 10) begin
                step();
                budget++;
            end
        end
        check("rand_final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_transfer_sequencer.md
REG_TRANSFER_SEQUENCER -- requirements
Module: reg_transfer_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of bus data, temporaries and immediate; all values below assume 8.
REQ-002 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-low; low forces reset state immediately.
REQ-004 Port reqValid, input, 1: requester offers an operation.
REQ-005 Port reqReady, output, 1: sequencer can accept an operation.
REQ-006 Port reqOp, input, 2: 00 MOV, 01 SWAP, 10 LDI (load immediate), 11 CLR.
REQ-007 Port reqSrc, input, 3: source register index (MOV, SWAP).
REQ-008 Port reqDst, input, 3: destination register index (all ops).
REQ-009 Port reqImm, input, DATA_WIDTH: immediate for LDI.
REQ-010 Port busIn, input, DATA_WIDTH: shared data bus as driven by the register file read port.
REQ-011 Port rOutSel, output, 3; rOutEn, output, 1: register file read select/enable.
REQ-012 Port rInSel, output, 3; rInEn, output, 1: register file write select/enable.
REQ-013 Port busOut, output, DATA_WIDTH: write data to register file input.
REQ-014 Port busy, output, 1: operation in progress; done, output, 1: one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, RD_A, RD_B, WR_A, WR_B; all outputs decoded from registered state/operand registers (Moore, no combinational path from request inputs to bus controls).
REQ-016 reqReady SHALL be 1 exactly in IDLE; a request is accepted on a rising edge with reqValid=1 and reqReady=1, latching reqOp, reqSrc, reqDst, reqImm.
REQ-017 Transitions on acceptance: MOV/SWAP -> RD_A; LDI/CLR -> WR_A. RD_A -> RD_B (SWAP) or WR_A (MOV). RD_B -> WR_A. WR_A -> WR_B (SWAP) or IDLE. WR_B -> IDLE.
REQ-018 RD_A: rOutEn=1, rOutSel=src; busIn captured into tmpA at the rising edge ending the cycle.
REQ-019 RD_B: rOutEn=1, rOutSel=dst; busIn captured into tmpB at the rising edge ending the cycle.
REQ-020 WR_A: rInEn=1, rInSel=dst, busOut = tmpA (MOV, SWAP), imm (LDI), 0 (CLR).
REQ-021 WR_B: rInEn=1, rInSel=src, busOut=tmpB.
REQ-022 rOutEn and rInEn SHALL never be 1 in the same cycle; both 0 in IDLE.
REQ-023 Bus cycle counts from acceptance edge: MOV 2, SWAP 4, LDI 1, CLR 1; next request acceptable on the edge ending the final write cycle's following IDLE cycle (one IDLE cycle minimum between operations).
REQ-024 done SHALL be 1 during the final write cycle only (WR_A for MOV/LDI/CLR, WR_B for SWAP); busy=1 in every non-IDLE state.
REQ-025 src==dst: MOV and SWAP execute the full cycle sequence unchanged; register value ends unmodified.
REQ-026 Inactive select outputs SHALL hold their last latched operand values; busOut SHALL be 0 when rInEn=0.
REQ-027 Request inputs changing while busy SHALL have no effect; reqValid held in IDLE with no edge yet SHALL cause no bus activity.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, rInEn=0, rOutEn=0, rInSel=0, rOutSel=0, busOut=0, tmpA=tmpB=0, busy=0, done=0, reqReady=0 while rst low; reqReady=1 from the first cycle after rst returns high.
REQ-029 rst asserted mid-operation SHALL abort with no further write enable; a partially executed SWAP is not completed.

Verification
REQ-030 MOV src=3 dst=5, bus returns 0xA7 in RD_A -> cycle1 rOutEn=1 rOutSel=3; cycle2 rInEn=1 rInSel=5 busOut=0xA7 done=1; cycle3 reqReady=1.
REQ-031 SWAP src=1 dst=6, bus 0x11 then 0x66 -> writes r6=0x11 (WR_A) then r1=0x66 (WR_B), done only in WR_B, busy 4 cycles.
REQ-032 LDI dst=7 imm=0x5C then CLR dst=2 back-to-back with reqValid held -> one write cycle each, busOut 0x5C then 0x00, one IDLE cycle between.
REQ-033 Every cycle of random op stream -> never rInEn&rOutEn, busOut=0 whenever rInEn=0, reqReady only when busy=0.
REQ-034 rst low during RD_B of SWAP -> enables drop immediately, no WR_A/WR_B, all outputs reset values; after release, MOV completes normally.
REQ-035 MOV src=dst=4 and SWAP src=dst=4 -> full 2/4-cycle sequences, written value equals value read.
